nco_epoch: RTL and testbench

Second-generation parametrised NCO for the GPS tracking channels, usable as a carrier NCO or a code NCO. It adds the following to a plain phase accumulator:
- quantised 2-bit sin/cos (I/Q) outputs;
- a modulo rollover counter (e.g. chip count) with an epoch pulse;
- a double-buffered step register that can be updated immediately or deferred to the next epoch.

It sits between the loop-filter register interface and the correlator mixers and code generator.

---
 rtl/nco_epoch.sv | 127 ++++++++++++
 tb/tb_nco_epoch.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_epoch.sv
// Parametrised NCO for GPS tracking channels: phase accumulator with 2-bit I/Q
// decode, modulo rollover counter with epoch pulse, and optionally deferred step updates.
module nco_epoch #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 10,
  parameter int CNT_LEN  = 1023,
  parameter int DEFER    = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                phase_sync,
  input  logic [WIDTH-1:0]    phase_in,
  input  logic [WIDTH-1:0]    step_in,
  input  logic                step_load,
  output logic [WIDTH-1:0]    phase_out,
  output logic [WIDTH-1:0]    step_out,
  output logic                carry,
  output logic [CNT_BITS-1:0] count,
  output logic                epoch,
  output logic                sin_sign,
  output logic                sin_mag,
  output logic                cos_sign,
  output logic                cos_mag
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(CNT_LEN - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic [WIDTH-1:0]    acc_r;
  logic [WIDTH-1:0]    step_active_r;
  logic [WIDTH-1:0]    step_pending_r;
  logic                pend_flag_r;
  logic [CNT_BITS-1:0] count_r;
  logic                carry_r;
  logic                epoch_r;

  logic [WIDTH:0]      sum_s;
  logic                ovf_s;
  logic                cnt_last_s;
  logic                epoch_set_s;
  logic                transfer_s;
  logic [2:0]          octant_s;
  logic [3:0]          iq_s;

  // Next-sum, overflow and step-transfer qualifiers
  always_comb begin
    sum_s       = {1'b0, acc_r} + {1'b0, step_active_r};
    ovf_s       = sum_s[WIDTH];
    cnt_last_s  = (count_r == CNT_MAX);
    epoch_set_s = enable & ~phase_sync & ovf_s & cnt_last_s;
    transfer_s  = phase_sync | epoch_set_s;
  end

  // Accumulator, rollover counter and carry/epoch pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r   <= '0;
      count_r <= '0;
      carry_r <= 1'b0;
      epoch_r <= 1'b0;
    end else if (phase_sync) begin
      acc_r   <= phase_in;
      count_r <= '0;
      carry_r <= 1'b0;
      epoch_r <= 1'b0;
    end else if (enable) begin
      acc_r   <= sum_s[WIDTH-1:0];
      carry_r <= ovf_s;
      if (ovf_s) begin
        count_r <= cnt_last_s ? '0 : count_r + CNT_ONE;
        epoch_r <= cnt_last_s;
      end else begin
        epoch_r <= 1'b0;
      end
    end else begin
      carry_r <= 1'b0;
      epoch_r <= 1'b0;
    end
  end

  // Active/pending step registers; a load coinciding with a transfer bypasses pending
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_active_r  <= '0;
      step_pending_r <= '0;
      pend_flag_r    <= 1'b0;
    end else if (DEFER == 0) begin
      if (step_load) begin
        step_active_r <= step_in;
      end
    end else if (transfer_s && (pend_flag_r || step_load)) begin
      step_active_r <= step_load ? step_in : step_pending_r;
      pend_flag_r   <= 1'b0;
    end else if (step_load) begin
      step_pending_r <= step_in;
      pend_flag_r    <= 1'b1;
    end
  end

  // Octant to {sin_sign, sin_mag, cos_sign, cos_mag}
  always_comb begin
    octant_s = acc_r[WIDTH-1:WIDTH-3];
    case (octant_s)
      3'd0:    iq_s = 4'b0001;
      3'd1:    iq_s = 4'b0100;
      3'd2:    iq_s = 4'b0110;
      3'd3:    iq_s = 4'b0011;
      3'd4:    iq_s = 4'b1011;
      3'd5:    iq_s = 4'b1110;
      3'd6:    iq_s = 4'b1100;
      3'd7:    iq_s = 4'b1001;
      default: iq_s = 4'b0001;
    endcase
  end

  assign phase_out = acc_r;
  assign step_out  = step_active_r;
  assign carry     = carry_r;
  assign count     = count_r;
  assign epoch     = epoch_r;
  assign sin_sign  = iq_s[3];
  assign sin_mag   = iq_s[2];
  assign cos_sign  = iq_s[1];
  assign cos_mag   = iq_s[0];

endmodule

// File: tb/tb_nco_epoch.sv
// Directed self-checking bench for nco_epoch: 32-bit immediate, 8-bit immediate
// and 8-bit deferred configurations driven from shared control strobes.
module tb_nco_epoch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        phase_sync = 1'b0;
  logic        step_load = 1'b0;
  logic [31:0] phase_in32 = 32'h0;
  logic [31:0] step_in32 = 32'h0;
  logic [7:0]  phase_in8 = 8'h0;
  logic [7:0]  step_in8 = 8'h0;

  logic [31:0] a_phase, a_step;
  logic [9:0]  a_count;
  logic        a_carry, a_epoch, a_ss, a_sm, a_cs, a_cm;
  logic [7:0]  b_phase, b_step;
  logic [1:0]  b_count;
  logic        b_carry, b_epoch, b_ss, b_sm, b_cs, b_cm;
  logic [7:0]  d_phase, d_step;
  logic [1:0]  d_count;
  logic        d_carry, d_epoch, d_ss, d_sm, d_cs, d_cm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nco_epoch #(.WIDTH(32), .CNT_BITS(10), .CNT_LEN(1023), .DEFER(0)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .phase_sync(phase_sync),
    .phase_in(phase_in32), .step_in(step_in32), .step_load(step_load),
    .phase_out(a_phase), .step_out(a_step), .carry(a_carry), .count(a_count),
    .epoch(a_epoch), .sin_sign(a_ss), .sin_mag(a_sm), .cos_sign(a_cs), .cos_mag(a_cm));

  nco_epoch #(.WIDTH(8), .CNT_BITS(2), .CNT_LEN(3), .DEFER(0)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .phase_sync(phase_sync),
    .phase_in(phase_in8), .step_in(step_in8), .step_load(step_load),
    .phase_out(b_phase), .step_out(b_step), .carry(b_carry), .count(b_count),
    .epoch(b_epoch), .sin_sign(b_ss), .sin_mag(b_sm), .cos_sign(b_cs), .cos_mag(b_cm));

  nco_epoch #(.WIDTH(8), .CNT_BITS(2), .CNT_LEN(3), .DEFER(1)) u_d (
    .clk(clk), .reset(reset), .enable(enable), .phase_sync(phase_sync),
    .phase_in(phase_in8), .step_in(step_in8), .step_load(step_load),
    .phase_out(d_phase), .step_out(d_step), .carry(d_carry), .count(d_count),
    .epoch(d_epoch), .sin_sign(d_ss), .sin_mag(d_sm), .cos_sign(d_cs), .cos_mag(d_cm));

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0; phase_sync = 1'b0; step_load = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b0; phase_sync = 1'b0; step_load = 1'b0;
    reset = 1'b0;
    #20;
    checks++;
    if ({a_phase, a_count, a_carry, a_epoch} !== 44'h0) begin
      errors++;
      $display("FAIL reset_state: phase=%h count=%0d carry=%b epoch=%b, required all 0", a_phase, a_count, a_carry, a_epoch);
    end
    checks++;
    if ({a_ss, a_sm, a_cs, a_cm} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_decode: sin/cos bits=%b, required 0001", {a_ss, a_sm, a_cs, a_cm});
    end
    @(negedge clk);
    reset = 1'b1;
    step_in32 = 32'h2000_0000; step_load = 1'b1;
    tick();
    step_load = 1'b0; enable = 1'b1;
    repeat (3) tick();
    checks++;
    if (a_phase !== 32'h6000_0000) begin
      errors++;
      $display("FAIL pre_reset_run: phase=%h, required 60000000", a_phase);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({a_phase, a_step, a_count} !== 74'h0) begin
      errors++;
      $display("FAIL async_reset: phase=%h step=%h count=%0d, required all 0", a_phase, a_step, a_count);
    end
    enable = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_octant_sweep();
    logic [7:0] sin_sgn_t = 8'b1111_0000;
    logic [7:0] sin_mag_t = 8'b0110_0110;
    logic [7:0] cos_sgn_t = 8'b0011_1100;
    logic [7:0] cos_mag_t = 8'b1001_1001;
    logic [31:0] exp_phase;
    logic [2:0]  o;
    do_reset();
    step_in32 = 32'h2000_0000; step_load = 1'b1;
    tick();
    step_load = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp_phase = 32'(i) * 32'h2000_0000;
      o = 3'(i % 8);
      checks++;
      if (a_phase !== exp_phase || a_carry !== (o == 3'd0)) begin
        errors++;
        $display("FAIL sweep_phase[%0d]: phase=%h carry=%b, required %h carry=%b", i, a_phase, a_carry, exp_phase, (o == 3'd0));
      end
      checks++;
      if ({a_ss, a_sm, a_cs, a_cm} !== {sin_sgn_t[o], sin_mag_t[o], cos_sgn_t[o], cos_mag_t[o]}) begin
        errors++;
        $display("FAIL sweep_iq[%0d]: bits=%b, required %b", i, {a_ss, a_sm, a_cs, a_cm},
                 {sin_sgn_t[o], sin_mag_t[o], cos_sgn_t[o], cos_mag_t[o]});
      end
    end
    checks++;
    if (a_count !== 10'd2) begin
      errors++;
      $display("FAIL sweep_count: count=%0d, required 2", a_count);
    end
    enable = 1'b0;
  endtask

  task automatic test_rollover();
    int n = 0;
    logic en;
    do_reset();
    step_in8 = 8'h40; step_load = 1'b1;
    tick();
    step_load = 1'b0;
    for (int k = 0; k < 36; k++) begin
      en = (k % 3) != 2;
      enable = en;
      tick();
      if (en) n++;
      checks++;
      if (b_phase !== 8'((n * 64) % 256) || b_count !== 2'((n / 4) % 3) ||
          b_carry !== (en && n % 4 == 0) || b_epoch !== (en && n % 12 == 0)) begin
        errors++;
        $display("FAIL rollover[%0d]: phase=%h count=%0d carry=%b epoch=%b, required %h %0d %b %b",
                 k, b_phase, b_count, b_carry, b_epoch, 8'((n * 64) % 256), (n / 4) % 3,
                 (en && n % 4 == 0), (en && n % 12 == 0));
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_deferred();
    do_reset();
    step_in8 = 8'h40; step_load = 1'b1; phase_sync = 1'b1; phase_in8 = 8'h00;
    tick();
    step_load = 1'b0; phase_sync = 1'b0;
    checks++;
    if (d_step !== 8'h40) begin
      errors++;
      $display("FAIL defer_sync_load: step=%h, required 40", d_step);
    end
    enable = 1'b1;
    repeat (5) tick();
    step_in8 = 8'h80; step_load = 1'b1;
    tick();
    step_load = 1'b0;
    repeat (5) tick();
    checks++;
    if (d_step !== 8'h40 || d_count !== 2'd2 || d_phase !== 8'hC0) begin
      errors++;
      $display("FAIL defer_hold: step=%h count=%0d phase=%h, required 40 2 c0", d_step, d_count, d_phase);
    end
    tick();
    checks++;
    if (d_step !== 8'h80 || d_epoch !== 1'b1 || d_phase !== 8'h00) begin
      errors++;
      $display("FAIL defer_epoch: step=%h epoch=%b phase=%h, required 80 1 00", d_step, d_epoch, d_phase);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (d_carry !== (i % 2 == 0) || d_count !== 2'(i / 2)) begin
        errors++;
        $display("FAIL defer_spacing[%0d]: carry=%b count=%0d, required %b %0d", i, d_carry, d_count, (i % 2 == 0), i / 2);
      end
    end
    tick();
    step_in8 = 8'h40; step_load = 1'b1;
    tick();
    step_load = 1'b0;
    checks++;
    if (d_epoch !== 1'b1 || d_step !== 8'h40) begin
      errors++;
      $display("FAIL defer_same_edge: epoch=%b step=%h, required 1 40", d_epoch, d_step);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (d_carry !== (i == 4) || d_step !== 8'h40) begin
        errors++;
        $display("FAIL defer_after[%0d]: carry=%b step=%h, required %b 40", i, d_carry, d_step, (i == 4));
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_phase_sync();
    do_reset();
    step_in32 = 32'h2000_0000; step_load = 1'b1;
    tick();
    step_load = 1'b0; enable = 1'b1;
    repeat (15) tick();
    checks++;
    if (a_phase !== 32'hE000_0000 || a_count !== 10'd1) begin
      errors++;
      $display("FAIL sync_setup: phase=%h count=%0d, required e0000000 1", a_phase, a_count);
    end
    phase_sync = 1'b1; phase_in32 = 32'hC000_0000;
    tick();
    phase_sync = 1'b0; enable = 1'b0;
    checks++;
    if (a_phase !== 32'hC000_0000 || a_count !== 10'd0 || a_carry !== 1'b0) begin
      errors++;
      $display("FAIL sync_priority: phase=%h count=%0d carry=%b, required c0000000 0 0", a_phase, a_count, a_carry);
    end
    checks++;
    if ({a_ss, a_sm, a_cs, a_cm} !== 4'b1100) begin
      errors++;
      $display("FAIL sync_decode: bits=%b, required 1100", {a_ss, a_sm, a_cs, a_cm});
    end
    do_reset();
    step_in8 = 8'h40; step_load = 1'b1;
    tick();
    step_load = 1'b0;
    checks++;
    if (d_step !== 8'h00) begin
      errors++;
      $display("FAIL sync_pending: step=%h, required 00", d_step);
    end
    phase_sync = 1'b1; phase_in8 = 8'hA0;
    tick();
    phase_sync = 1'b0;
    checks++;
    if (d_step !== 8'h40 || d_phase !== 8'hA0) begin
      errors++;
      $display("FAIL sync_transfer: step=%h phase=%h, required 40 a0", d_step, d_phase);
    end
  endtask

  task automatic test_immediate_wrap();
    do_reset();
    phase_sync = 1'b1; phase_in8 = 8'hF0;
    tick();
    phase_sync = 1'b0;
    step_in8 = 8'h20; step_load = 1'b1;
    tick();
    step_load = 1'b0;
    checks++;
    if (b_step !== 8'h20 || b_phase !== 8'hF0) begin
      errors++;
      $display("FAIL imm_load: step=%h phase=%h, required 20 f0", b_step, b_phase);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (b_phase !== 8'h10 || b_carry !== 1'b1 || b_count !== 2'd1) begin
      errors++;
      $display("FAIL imm_wrap: phase=%h carry=%b count=%0d, required 10 1 1", b_phase, b_carry, b_count);
    end
    enable = 1'b0; step_in8 = 8'h00; step_load = 1'b1;
    tick();
    step_load = 1'b0; enable = 1'b1;
    repeat (2) tick();
    checks++;
    if (b_phase !== 8'h10 || b_carry !== 1'b0) begin
      errors++;
      $display("FAIL zero_step: phase=%h carry=%b, required 10 0", b_phase, b_carry);
    end
    step_in8 = 8'h30; step_load = 1'b1;
    tick();
    step_load = 1'b0;
    checks++;
    if (b_phase !== 8'h10 || b_step !== 8'h30) begin
      errors++;
      $display("FAIL imm_latency: phase=%h step=%h, required 10 30", b_phase, b_step);
    end
    tick();
    checks++;
    if (b_phase !== 8'h40) begin
      errors++;
      $display("FAIL imm_use: phase=%h, required 40", b_phase);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_octant_sweep();
    test_rollover();
    test_deferred();
    test_phase_sync();
    test_immediate_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
